// File: rtl/stream_pkg.sv
// stream_pkg: shared types and header layout for the packet stream mux
package stream_pkg;
  typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;
  localparam int HDR_MAGIC_LSB = 56;
  localparam int HDR_SRC_LSB = 48;
  localparam int HDR_SEQ_LSB = 32;
  localparam int HDR_PKT_LSB = 16;
  localparam logic [7:0] HDR_MAGIC_DEF = 8'hA5;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first requester after last
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] grant,
  output logic         any
);
  int best;
  always_comb begin
    grant = '0;
    best = N;
    for (int j = 0; j < N; j++) begin
      if (req[j] && ((j + N - 1 - int'(last)) % N) < best) begin
        best = (j + N - 1 - int'(last)) % N;
        grant = W'(j);
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/stream_pkt_mux.sv
// stream_pkt_mux: packet-granular round-robin merge with header prefix and orphan drop
module stream_pkt_mux
  import stream_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W = 3,
  parameter logic [7:0] HDR_MAGIC = HDR_MAGIC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [NUM_SRC*64-1:0] in_tdata,
  input  logic [NUM_SRC-1:0]   in_tfirst,
  input  logic [NUM_SRC-1:0]   in_tlast,
  input  logic [NUM_SRC-1:0]   in_tvalid,
  output logic [NUM_SRC-1:0]   in_tready,
  output logic [63:0]          out_tdata,
  output logic                 out_tfirst,
  output logic                 out_tlast,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic [15:0]          drop_count,
  output logic [15:0]          pkt_count
);
  // per-source vectors padded to the full index range so grant indexes them exactly
  localparam int NP = 2 ** SRC_W;
  state_t state, state_n;
  logic [SRC_W-1:0] grant, last_grant, pick;
  logic any_req, dvalid, dlast, done;
  logic [15:0] seq [NP];
  logic [NP-1:0] first_p, last_p, valid_p, ready_p;
  logic [63:0] data_p [NP];
  logic [63:0] hdr;
  assign first_p = NP'(in_tfirst);
  assign last_p = NP'(in_tlast);
  assign valid_p = NP'(in_tvalid);
  always_comb begin
    data_p = '{default: '0};
    for (int i = 0; i < NUM_SRC; i++) data_p[i] = in_tdata[64*i +: 64];
  end
  assign dvalid = valid_p[grant];
  assign dlast = last_p[grant];
  assign done = dvalid && dlast && (state == DROP || (state == DATA && out_tready));
  rr_pick #(.N(NUM_SRC), .W(SRC_W)) u_pick (
    .req(in_tvalid),
    .last(last_grant),
    .grant(pick),
    .any(any_req)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= SRC_W'(NUM_SRC - 1);
      seq <= '{default: '0};
      pkt_count <= '0;
      drop_count <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && ena && any_req) begin
        grant <= pick;
        last_grant <= pick;
      end
      if (state == DATA && done) begin
        seq[grant] <= seq[grant] + 16'd1;
        pkt_count <= pkt_count + 16'd1;
      end
      if (state == DROP && done && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
  always_comb begin
    state_n = state == IDLE ? ((ena && any_req) ? (first_p[pick] ? HDR : DROP) : IDLE)
            : state == HDR ? (out_tready ? DATA : HDR)
            : done ? IDLE : state;
  end
  always_comb begin
    hdr = '0;
    hdr[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
    hdr[HDR_SRC_LSB +: 8] = 8'(grant);
    hdr[HDR_SEQ_LSB +: 16] = seq[grant];
    hdr[HDR_PKT_LSB +: 16] = pkt_count;
    ready_p = '0;
    ready_p[grant] = state == DATA ? out_tready : state == DROP;
    out_tvalid = state == HDR || (state == DATA && dvalid);
    out_tfirst = state == HDR;
    out_tlast = state == DATA && dlast;
    out_tdata = state == HDR ? hdr : state == DATA ? data_p[grant] : '0;
  end
  assign in_tready = ready_p[NUM_SRC-1:0];
endmodule

// File: tb/tb_stream_pkt_mux.sv
// tb_stream_pkt_mux: vector table, directed sequences and randomized packet-level model check
module tb_stream_pkt_mux;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst, ena, out_tfirst, out_tlast, out_tvalid, out_tready;
  logic [N*64-1:0] in_tdata;
  logic [N-1:0] in_tfirst, in_tlast, in_tvalid, in_tready;
  logic [63:0] out_tdata;
  logic [15:0] drop_count, pkt_count;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  stream_pkt_mux dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_tdata(in_tdata), .in_tfirst(in_tfirst), .in_tlast(in_tlast),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tfirst(out_tfirst), .out_tlast(out_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready),
    .drop_count(drop_count), .pkt_count(pkt_count)
  );
  // word format: {tfirst, tlast, tdata}
  logic [65:0] src_q [N][$];
  logic [65:0] exp_q [$];
  logic [63:0] hdr_log [$];
  int m_last;
  logic [15:0] m_seq [N];
  logic [15:0] m_pkt, m_drop;
  logic prev_stall;
  logic [66:0] prev_out;
  int cyc;
  typedef struct {
    logic v; logic [63:0] d; logic f; logic l; logic rdy;
    logic ov; logic of; logic ol; logic [3:0] itr; logic [63:0] od;
  } vec_t;
  vec_t tv [10];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit idle_all();
    bit r = exp_q.size() == 0;
    for (int s = 0; s < N; s++) if (src_q[s].size() != 0) r = 0;
    return r;
  endfunction

  task automatic model_clear();
    foreach (src_q[s]) src_q[s].delete();
    exp_q.delete();
    hdr_log.delete();
    m_last = N - 1;
    foreach (m_seq[s]) m_seq[s] = '0;
    m_pkt = '0;
    m_drop = '0;
    prev_stall = 0;
    cyc = 0;
  endtask

  task automatic add_pkt(input int s, input int len, input bit orphan, input logic [63:0] base, input bit midf);
    for (int k = 0; k < len; k++) begin
      logic f = (k == 0) ? !orphan : (!orphan && midf && $urandom_range(0, 7) == 0);
      src_q[s].push_back({f, k == len - 1, base + 64'(k)});
    end
  endtask

  // packet-level reference: round-robin over sources with pending words
  task automatic model_build();
    logic [65:0] mq [N][$];
    logic [65:0] w;
    int s;
    for (int i = 0; i < N; i++) mq[i] = src_q[i];
    while (1) begin
      s = -1;
      for (int k = 1; k <= N; k++) begin
        int c = (m_last + k) % N;
        if (s < 0 && mq[c].size() > 0) s = c;
      end
      if (s < 0) break;
      m_last = s;
      w = mq[s].pop_front();
      if (w[65]) begin
        exp_q.push_back({2'b10, 8'hA5, 8'(s), m_seq[s], m_pkt, 16'h0});
        exp_q.push_back({1'b0, w[64:0]});
        while (!w[64]) begin
          w = mq[s].pop_front();
          exp_q.push_back({1'b0, w[64:0]});
        end
        m_seq[s]++;
        m_pkt++;
      end else begin
        while (!w[64]) w = mq[s].pop_front();
        if (m_drop != 16'hFFFF) m_drop++;
      end
    end
  endtask

  task automatic drive_src();
    for (int s = 0; s < N; s++) begin
      logic [65:0] w = src_q[s].size() > 0 ? src_q[s][0] : '0;
      in_tvalid[s] = src_q[s].size() > 0;
      in_tfirst[s] = w[65];
      in_tlast[s] = w[64];
      in_tdata[64*s +: 64] = w[63:0];
    end
  endtask

  task automatic cycle(input int rmode, input int emode);
    drive_src();
    out_tready = rmode == 0 ? 1'b1 : rmode == 1 ? ($urandom_range(0, 3) != 0) : (cyc % 4 == 0 || cyc % 4 == 3);
    ena = emode == 0 ? 1'b0 : emode == 1 ? 1'b1 : ($urandom_range(0, 1) == 1);
    cyc++;
    #1;
    if (prev_stall) check("stall_hold", {out_tvalid, out_tfirst, out_tlast, out_tdata}, {1'b1, prev_out[65:0]});
    if (out_tvalid && !out_tfirst) check("ready_mirror", |in_tready, out_tready);
    check("ready_onehot", $countones(in_tready) <= 1, 1);
    if (out_tvalid && out_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got %h expected no word", out_tdata);
      end else check("out_word", {out_tfirst, out_tlast, out_tdata}, exp_q.pop_front());
      if (out_tfirst) hdr_log.push_back(out_tdata);
    end
    prev_stall = out_tvalid && !out_tready;
    prev_out = {1'b0, out_tfirst, out_tlast, out_tdata};
    for (int s = 0; s < N; s++) if (in_tvalid[s] && in_tready[s]) void'(src_q[s].pop_front());
    @(negedge clk);
  endtask

  task automatic run(input int maxc, input int rmode, input int emode, input bit drain, input string name);
    for (int c = 0; c < maxc; c++) begin
      if (drain && idle_all()) break;
      cycle(rmode, emode);
    end
    if (drain) check({name, "_drain"}, idle_all(), 1);
  endtask

  task automatic do_reset();
    rst = 1;
    ena = 0;
    out_tready = 0;
    in_tvalid = '0;
    in_tfirst = '0;
    in_tlast = '0;
    in_tdata = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic check_hdr(input string name, input int idx, input logic [63:0] exp);
    if (hdr_log.size() <= idx) check(name, hdr_log.size(), idx + 1);
    else check(name, hdr_log[idx], exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{1, 64'h11, 1, 0, 1, 0, 0, 0, 4'h0, 64'h0};
    tv[1] = '{1, 64'h11, 1, 0, 1, 1, 1, 0, 4'h0, 64'hA500_0000_0000_0000};
    tv[2] = '{1, 64'h11, 1, 0, 0, 1, 0, 0, 4'h0, 64'h11};
    tv[3] = '{1, 64'h11, 1, 0, 1, 1, 0, 0, 4'h1, 64'h11};
    tv[4] = '{1, 64'h22, 0, 0, 1, 1, 0, 0, 4'h1, 64'h22};
    tv[5] = '{1, 64'h33, 0, 1, 1, 1, 0, 1, 4'h1, 64'h33};
    tv[6] = '{1, 64'h44, 1, 1, 1, 0, 0, 0, 4'h0, 64'h0};
    tv[7] = '{1, 64'h44, 1, 1, 1, 1, 1, 0, 4'h0, 64'hA500_0001_0001_0000};
    tv[8] = '{1, 64'h44, 1, 1, 1, 1, 0, 1, 4'h1, 64'h44};
    tv[9] = '{0, 64'h0, 0, 0, 1, 0, 0, 0, 4'h0, 64'h0};
    do_reset();
    #1;
    check("rst_outputs", {out_tvalid, out_tfirst, out_tlast, in_tready, out_tdata}, '0);
    check("rst_counts", {pkt_count, drop_count}, '0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      in_tvalid = {3'b0, tv[i].v};
      in_tfirst = {3'b0, tv[i].f};
      in_tlast = {3'b0, tv[i].l};
      in_tdata = {192'b0, tv[i].d};
      out_tready = tv[i].rdy;
      ena = 1;
      #1;
      check($sformatf("vec%0d", i), {out_tvalid, out_tfirst, out_tlast, in_tready, out_tdata},
            {tv[i].ov, tv[i].of, tv[i].ol, tv[i].itr, tv[i].od});
      @(negedge clk);
    end
    check("vec_pkt_count", pkt_count, 2);

    do_reset();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) add_pkt(s, 2, 0, 64'(16 * r + s) << 8, 0);
    model_build();
    run(200, 0, 1, 1, "rr");
    check_hdr("rr_hdr6", 6, 64'hA502_0001_0006_0000);
    check("rr_pkt_count", pkt_count, 8);

    do_reset();
    add_pkt(1, 4, 1, 64'h100, 0);
    add_pkt(1, 2, 0, 64'h200, 0);
    model_build();
    run(100, 0, 1, 1, "drop");
    check("drop_count", drop_count, 1);
    check_hdr("drop_next_hdr", 0, 64'hA501_0000_0000_0000);

    do_reset();
    add_pkt(0, 5, 0, 64'h300, 0);
    model_build();
    run(100, 2, 1, 1, "bp");
    check("bp_pkt_count", pkt_count, 1);

    do_reset();
    add_pkt(2, 3, 0, 64'h400, 0);
    add_pkt(3, 2, 0, 64'h500, 0);
    model_build();
    run(3, 0, 1, 0, "ena_on");
    run(12, 0, 0, 0, "ena_off");
    check("ena_hold_pending", exp_q.size(), 3);
    run(50, 0, 1, 1, "ena_resume");
    check_hdr("ena_resume_hdr", 1, 64'hA503_0000_0001_0000);

    do_reset();
    add_pkt(0, 2, 0, 64'h600, 0);
    add_pkt(0, 5, 0, 64'h700, 0);
    model_build();
    run(8, 0, 1, 0, "pre_rst");
    check("pre_rst_pkt_count", pkt_count, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_clear();
    drive_src();
    #1;
    check("mid_rst_state", {out_tvalid, in_tready, pkt_count, drop_count}, '0);
    @(negedge clk);
    add_pkt(0, 2, 0, 64'h800, 0);
    model_build();
    run(50, 0, 1, 1, "post_rst");
    check_hdr("post_rst_hdr", 0, 64'hA500_0000_0000_0000);

    do_reset();
    for (int it = 0; it < 3; it++) begin
      for (int s = 0; s < N; s++)
        for (int p = 0; p < 8; p++)
          add_pkt(s, $urandom_range(1, 6), $urandom_range(0, 6) == 0, {$urandom, $urandom}, 1);
      model_build();
      run(4000, 1, 2, 1, "rand");
      check("rand_pkt_count", pkt_count, m_pkt);
      check("rand_drop_count", drop_count, m_drop);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
